// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory stage.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    DONE    = 2'd2
  } state_t;

  // Offsets inside the MMIO page (Addr[15:0]).
  localparam logic [15:0] LED_OFS = 16'h0000;
  localparam logic [15:0] SW_OFS  = 16'h0004;

  // Little-endian byte extract: lane 0 is bits [7:0].
  function automatic logic [7:0] lane_byte(input logic [31:0] word, input logic [1:0] lane);
    logic [7:0] b;
    case (lane)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/dmem_ctrl_sync2.sv
// Two-flop synchroniser for asynchronous level inputs.
module sync2 #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  // Two register stages, both cleared by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory stage: RAM bridge with variable read latency plus LED/switch MMIO page.
//
// Handshake: the core raises MemRead and holds Addr/ByteOp stable while Stall=1;
// the load completes in the cycle where MemRead=1 and Stall=0, and ReadData is
// valid in that cycle. Stores complete in the cycle MemWrite is seen in IDLE.
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int          RAM_AW  = 8,
  parameter int          RAM_LAT = 1,
  parameter logic [31:0] IO_BASE = 32'hFFFF_0000,
  parameter int          LED_W   = 10,
  parameter int          SW_W    = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic              ByteOp,
  input  logic [31:0]       Addr,
  input  logic [31:0]       WriteData,
  output logic [31:0]       ReadData,
  output logic              Stall,
  output logic              MisalignErr,
  output logic [RAM_AW-1:0] ram_addr,
  output logic              ram_we,
  output logic [3:0]        ram_be,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata,
  output logic [LED_W-1:0]  led,
  input  logic [SW_W-1:0]   sw,
  output state_t            dbg_state
);

  localparam logic [2:0] LAT = 3'(RAM_LAT);

  state_t      state, state_nx;
  logic [2:0]  cnt, cnt_nx;
  logic [31:0] rdata_q;
  logic [31:0] load_val, io_rval;
  logic [SW_W-1:0] sw_s;
  logic        io_sel, misalign;
  logic        cap_ram, cap_io, led_we;
  logic [15:0] io_ofs;

  sync2 #(.W(SW_W)) u_sw_sync (
    .clk   (clk),
    .reset (reset),
    .d     (sw),
    .q     (sw_s)
  );

  assign io_sel    = (Addr[31:16] == IO_BASE[31:16]);
  assign io_ofs    = Addr[15:0];
  // Addresses beyond the RAM wrap: upper word-address bits are simply dropped.
  assign ram_addr  = Addr[RAM_AW+1:2];
  assign ram_wdata = ByteOp ? {4{WriteData[7:0]}} : WriteData;
  assign misalign  = (MemRead | MemWrite) & ~ByteOp & (Addr[1:0] != 2'b00);
  assign ReadData  = rdata_q;
  assign dbg_state = state;

  // Lane processing of RAM data and MMIO read mux.
  always_comb begin
    load_val = ByteOp ? {24'h0, lane_byte(ram_rdata, Addr[1:0])} : ram_rdata;
    io_rval  = '0;
    if (io_ofs == SW_OFS) begin
      io_rval[SW_W-1:0] = sw_s;
    end else if (io_ofs == LED_OFS) begin
      io_rval[LED_W-1:0] = led;
    end
  end

  // Next-state, stall and strobe decode; MemWrite wins when both requests are up.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    Stall    = 1'b0;
    ram_we   = 1'b0;
    cap_ram  = 1'b0;
    cap_io   = 1'b0;
    led_we   = 1'b0;
    case (state)
      IDLE: begin
        if (MemWrite) begin
          ram_we = ~io_sel & ~reset;
          led_we = io_sel & (io_ofs == LED_OFS);
        end else if (MemRead) begin
          Stall = 1'b1;
          if (io_sel) begin
            cap_io   = 1'b1;
            state_nx = DONE;
          end else begin
            state_nx = RD_WAIT;
            cnt_nx   = 3'd1;
          end
        end
      end
      RD_WAIT: begin
        Stall = 1'b1;
        if (!MemRead) begin
          state_nx = IDLE;
          cnt_nx   = 3'd0;
        end else if (cnt == LAT) begin
          cap_ram  = 1'b1;
          state_nx = DONE;
          cnt_nx   = 3'd0;
        end else begin
          cnt_nx = cnt + 3'd1;
        end
      end
      DONE: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
        cnt_nx   = 3'd0;
      end
    endcase
  end

  // Byte enables only assert alongside the write strobe.
  always_comb begin
    ram_be = 4'h0;
    if (ram_we) begin
      ram_be = ByteOp ? (4'b0001 << Addr[1:0]) : 4'hF;
    end
  end

  // State, wait counter, read-data capture, LED register and sticky error flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= 3'd0;
      rdata_q     <= 32'h0;
      led         <= '0;
      MisalignErr <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (cap_ram) rdata_q <= load_val;
      if (cap_io)  rdata_q <= io_rval;
      if (led_we)  led     <= WriteData[LED_W-1:0];
      if (misalign) MisalignErr <= 1'b1;
    end
  end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Bench for dmem_ctrl: three instances (RAM_LAT 1,2,3) share core-side stimulus,
// each with its own behavioural RAM; loads are scored through an expected queue.
module tb_dmem_ctrl;
  import dmem_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemRead, MemWrite, ByteOp;
  logic [31:0] Addr, WriteData;
  logic [9:0]  sw;

  logic [31:0] rd_v   [3];
  logic [2:0]  stall_v;
  logic [2:0]  mis_v;
  logic [2:0]  we_v;
  logic [3:0]  be_v   [3];
  logic [31:0] wd_v   [3];
  logic [9:0]  led_v  [3];
  state_t      dbg_v  [3];

  logic [31:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  // clock / reset block
  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int L = g + 1;
    logic [7:0]  ra;
    logic [31:0] rdat;
    logic [31:0] mem  [256];
    logic [31:0] pipe [L];

    dmem_ctrl #(
      .RAM_AW(8), .RAM_LAT(L), .IO_BASE(32'hFFFF_0000), .LED_W(10), .SW_W(10)
    ) u_dut (
      .clk(clk), .reset(reset), .MemRead(MemRead), .MemWrite(MemWrite), .ByteOp(ByteOp),
      .Addr(Addr), .WriteData(WriteData), .ReadData(rd_v[g]), .Stall(stall_v[g]),
      .MisalignErr(mis_v[g]), .ram_addr(ra), .ram_we(we_v[g]), .ram_be(be_v[g]),
      .ram_wdata(wd_v[g]), .ram_rdata(rdat), .led(led_v[g]), .sw(sw), .dbg_state(dbg_v[g])
    );

    initial begin
      for (int i = 0; i < 256; i++) mem[i] = 32'h0;
      for (int i = 0; i < L; i++) pipe[i] = 32'h0;
    end

    // synchronous RAM: byte-enabled write, L-cycle registered read
    always @(posedge clk) begin
      pipe[0] <= mem[ra];
      for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
      if (we_v[g]) begin
        for (int b = 0; b < 4; b++)
          if (be_v[g][b]) mem[ra][8*b +: 8] <= wd_v[g][8*b +: 8];
      end
    end
    assign rdat = pipe[L-1];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic idle_cycle();
    @(posedge clk); #1;
    MemRead = 1'b0; MemWrite = 1'b0;
  endtask

  // driver: one store, checking the RAM strobes of instance 0
  task automatic do_store(input logic [31:0] a, input logic b, input logic [31:0] d,
                          input logic also_rd);
    logic       io;
    logic [3:0] exp_be;
    io     = (a[31:16] == 16'hFFFF);
    exp_be = io ? 4'h0 : (b ? (4'b0001 << a[1:0]) : 4'hF);
    @(posedge clk); #1;
    MemWrite = 1'b1; MemRead = also_rd; ByteOp = b; Addr = a; WriteData = d;
    @(negedge clk);
    check("st_stall", {31'h0, stall_v[0]}, 32'h0);
    check("st_we", {31'h0, we_v[0]}, {31'h0, ~io});
    check("st_be", {28'h0, be_v[0]}, {28'h0, exp_be});
    if (!io) check("st_wdata", wd_v[0], b ? {4{d[7:0]}} : d);
    idle_cycle();
  endtask

  // driver: one load on instance k, scored against exp_q, with stall-cycle count
  task automatic do_load(input int k, input logic [31:0] a, input logic b,
                         input logic [31:0] exp, input int exp_stalls);
    int   stalls;
    logic done;
    exp_q.push_back(exp);
    @(posedge clk); #1;
    MemRead = 1'b1; MemWrite = 1'b0; ByteOp = b; Addr = a;
    stalls = 0;
    done   = 1'b0;
    for (int c = 0; c < 20 && !done; c++) begin
      @(negedge clk);
      if (stall_v[k]) begin
        stalls++;
        @(posedge clk); #1;
      end else begin
        done = 1'b1;
      end
    end
    if (!done) begin
      check("ld_timeout", 32'h1, 32'h0);
      void'(exp_q.pop_front());
    end else begin
      check("ld_data", rd_v[k], exp_q.pop_front());
      check("ld_stalls", 32'(stalls), 32'(exp_stalls));
    end
    idle_cycle();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; MemRead = 1'b0; MemWrite = 1'b0; ByteOp = 1'b0;
    Addr = 32'h0; WriteData = 32'h0; sw = 10'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      check("rst_stall", {31'h0, stall_v[k]}, 32'h0);
      check("rst_rdata", rd_v[k], 32'h0);
      check("rst_led", {22'h0, led_v[k]}, 32'h0);
      check("rst_we", {31'h0, we_v[k]}, 32'h0);
      check("rst_be", {28'h0, be_v[k]}, 32'h0);
      check("rst_mis", {31'h0, mis_v[k]}, 32'h0);
      check("rst_state", 32'(dbg_v[k]), 32'(IDLE));
    end
    @(posedge clk); #1;
    reset = 1'b0;

    // word store/load, RAM_LAT=1: 2 stall cycles
    do_store(32'h10, 1'b0, 32'hDEADBEEF, 1'b0);
    do_load(0, 32'h10, 1'b0, 32'hDEADBEEF, 2);

    // byte store into lane 3, then read back word and bytes
    do_store(32'h13, 1'b1, 32'h000000A5, 1'b0);
    do_load(0, 32'h10, 1'b0, 32'hA5ADBEEF, 2);
    do_store(32'h10, 1'b0, 32'h11223344, 1'b0);
    do_load(0, 32'h13, 1'b1, 32'h00000011, 2);
    do_load(0, 32'h11, 1'b1, 32'h00000033, 2);

    // MemRead and MemWrite together behave as a store
    do_store(32'h14, 1'b0, 32'h55AA55AA, 1'b1);
    do_load(0, 32'h14, 1'b0, 32'h55AA55AA, 2);

    // word address wraps modulo 256 words
    do_store(32'h408, 1'b0, 32'h0BADCAFE, 1'b0);
    do_load(0, 32'h8, 1'b0, 32'h0BADCAFE, 2);

    // MMIO: LED write, switch and LED reads, unmapped offset reads zero
    sw = 10'h155;
    do_store(32'hFFFF0000, 1'b0, 32'h000003FF, 1'b0);
    check("led", {22'h0, led_v[0]}, 32'h3FF);
    do_store(32'hFFFF0004, 1'b0, 32'h00000001, 1'b0);
    check("led_sw_ofs", {22'h0, led_v[0]}, 32'h3FF);
    do_load(0, 32'hFFFF0004, 1'b0, 32'h155, 1);
    do_load(0, 32'hFFFF0000, 1'b0, 32'h3FF, 1);
    do_load(0, 32'hFFFF0008, 1'b0, 32'h0, 1);

    // misaligned word load sets the sticky flag; data from the enclosing word
    check("mis_pre", {31'h0, mis_v[0]}, 32'h0);
    do_store(32'h20, 1'b0, 32'hCAFEF00D, 1'b0);
    do_load(0, 32'h22, 1'b0, 32'hCAFEF00D, 2);
    check("mis_set", {31'h0, mis_v[0]}, 32'h1);
    do_load(0, 32'h20, 1'b0, 32'hCAFEF00D, 2);
    check("mis_sticky", {31'h0, mis_v[0]}, 32'h1);

    // RAM_LAT=3 load: 4 stall cycles
    do_load(2, 32'h10, 1'b0, 32'h11223344, 4);

    // back-to-back loads on RAM_LAT=2 instance, MemRead held throughout
    exp_q.push_back(32'h11223344);
    exp_q.push_back(32'hCAFEF00D);
    @(posedge clk); #1;
    MemRead = 1'b1; MemWrite = 1'b0; ByteOp = 1'b0; Addr = 32'h10;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      check("b2b_stall", {31'h0, stall_v[1]}, {31'h0, (c % 4) != 3});
      if (!stall_v[1]) begin
        if (exp_q.size() == 0) check("b2b_queue", 32'h1, 32'h0);
        else check("b2b_data", rd_v[1], exp_q.pop_front());
      end
      if (c == 4) check("b2b_idle", 32'(dbg_v[1]), 32'(IDLE));
      if (c == 5) check("b2b_rdwait", 32'(dbg_v[1]), 32'(RD_WAIT));
      @(posedge clk); #1;
      if (c == 3) Addr = 32'h20;
    end
    MemRead = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // reset in the middle of a RAM_LAT=3 wait, with a store request in the reset cycle
    MemRead = 1'b1; Addr = 32'h10; ByteOp = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    check("mid_state", 32'(dbg_v[2]), 32'(RD_WAIT));
    @(posedge clk); #1;
    reset = 1'b1; MemRead = 1'b0; MemWrite = 1'b1; Addr = 32'h30; WriteData = 32'h12345678;
    @(negedge clk);
    check("rstcyc_we", {31'h0, we_v[2]}, 32'h0);
    @(posedge clk); #1;
    reset = 1'b0; MemWrite = 1'b0;
    @(negedge clk);
    check("post_stall", {31'h0, stall_v[2]}, 32'h0);
    check("post_rdata", rd_v[2], 32'h0);
    check("post_led", {22'h0, led_v[2]}, 32'h0);
    check("post_we", {31'h0, we_v[2]}, 32'h0);
    check("post_mis", {31'h0, mis_v[2]}, 32'h0);
    check("post_state", 32'(dbg_v[2]), 32'(IDLE));
    do_load(2, 32'h30, 1'b0, 32'h0, 4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
